// File: rtl/apb_sram_if.sv
// APB bus bundle between the AHB-to-APB bridge (master) and the SRAM slave.
// PCLKEN travels with the bus so both ends see the same APB timing.
interface apb_sram_if #(
    parameter int ADDRWIDTH = 16
);
    logic                 PCLKEN;
    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic [31:0]          PWDATA;
    logic [3:0]           PSTRB;
    logic [2:0]           PPROT;
    logic [31:0]          PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    modport master (
        output PCLKEN, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PCLKEN, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_sram_slave.sv
// Word-organised SRAM behind an APB slave port: programmable wait states,
// byte-strobe writes, and error responses for out-of-range/privileged words.
module apb_sram_slave #(
    parameter int ADDRWIDTH   = 16,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0,
    parameter int PRIV_WORDS  = 0
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    apb_sram_if.slave  bus
);
    localparam int IDXW = ADDRWIDTH - 2;
    localparam int MIW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [IDXW:0] MEM_LIM  = (IDXW+1)'(MEM_WORDS);
    localparam logic [IDXW:0] PRIV_LIM = (IDXW+1)'(PRIV_WORDS);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q;
    logic [3:0]  wait_cnt_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_q [MEM_WORDS];

    logic [IDXW-1:0] idx;
    logic [MIW-1:0]  mem_idx;
    logic            err_c;
    logic            done_c;
    logic            wr_en;
    logic            unused_ok;

    assign idx     = bus.PADDR[ADDRWIDTH-1:2];
    assign mem_idx = idx[MIW-1:0];
    // Upper index bits only feed the range check; they never address the array.
    assign err_c   = ({1'b0, idx} >= MEM_LIM) |
                     (({1'b0, idx} < PRIV_LIM) & ~bus.PPROT[0]);

    assign done_c  = (state_q == ACCESS) & (wait_cnt_q == 4'd0);
    assign wr_en   = bus.PCLKEN & done_c & bus.PSEL & bus.PENABLE &
                     bus.PWRITE & ~err_q;

    assign unused_ok = ^{bus.PADDR[1:0], bus.PPROT[2:1]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
        end else if (bus.PCLKEN) begin
            case (state_q)
                IDLE: begin
                    // PSEL with PENABLE already high has no setup phase: ignore it.
                    if (bus.PSEL && !bus.PENABLE) begin
                        state_q    <= ACCESS;
                        wait_cnt_q <= 4'(WAIT_STATES);
                        err_q      <= err_c;
                        rdata_q    <= (!bus.PWRITE && !err_c) ? mem_q[mem_idx] : 32'd0;
                    end
                end
                ACCESS: begin
                    if (!bus.PSEL) begin
                        state_q <= IDLE;
                    end else if (wait_cnt_q != 4'd0) begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end else if (bus.PENABLE) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage is deliberately unreset so contents survive HRESETn.
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.PSTRB[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= bus.PWDATA[8*b +: 8];
                end
            end
        end
    end

    assign bus.PREADY  = (state_q == IDLE) | done_c;
    assign bus.PSLVERR = done_c & err_q;
    assign bus.PRDATA  = (done_c && !bus.PWRITE && !err_q) ? rdata_q : 32'd0;
endmodule

// File: tb/tb_apb_sram_slave.sv
// Scoreboard bench: two slave configurations (no waits + privileged words,
// three waits) share one APB driver; a negedge monitor checks completions.
module tb_apb_sram_slave;
    logic        HCLK;
    logic        hresetn;
    logic        pclken;
    logic        toggle;
    logic        dsel;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        xfer_active;
    string       tname;

    int checks;
    int errors;
    int mon_w;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          w;
    } exp_t;
    exp_t q[$];

    apb_sram_if #(.ADDRWIDTH(16)) ifa ();
    apb_sram_if #(.ADDRWIDTH(16)) ifb ();

    assign ifa.PCLKEN = pclken;   assign ifb.PCLKEN = pclken;
    assign ifa.PSEL   = psel & ~dsel;
    assign ifb.PSEL   = psel & dsel;
    assign ifa.PENABLE = penable; assign ifb.PENABLE = penable;
    assign ifa.PWRITE = pwrite;   assign ifb.PWRITE = pwrite;
    assign ifa.PADDR  = paddr;    assign ifb.PADDR  = paddr;
    assign ifa.PWDATA = pwdata;   assign ifb.PWDATA = pwdata;
    assign ifa.PSTRB  = pstrb;    assign ifb.PSTRB  = pstrb;
    assign ifa.PPROT  = pprot;    assign ifb.PPROT  = pprot;

    logic        pready_m, pslverr_m;
    logic [31:0] prdata_m;
    assign pready_m  = dsel ? ifb.PREADY  : ifa.PREADY;
    assign pslverr_m = dsel ? ifb.PSLVERR : ifa.PSLVERR;
    assign prdata_m  = dsel ? ifb.PRDATA  : ifa.PRDATA;

    apb_sram_slave #(.ADDRWIDTH(16), .MEM_WORDS(1024), .WAIT_STATES(0), .PRIV_WORDS(4))
        dut0 (.HCLK(HCLK), .HRESETn(hresetn), .bus(ifa.slave));
    apb_sram_slave #(.ADDRWIDTH(16), .MEM_WORDS(1024), .WAIT_STATES(3), .PRIV_WORDS(0))
        dut1 (.HCLK(HCLK), .HRESETn(hresetn), .bus(ifb.slave));

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // PCLKEN changes shortly after the rising edge, so it is stable at both edges.
    initial begin
        pclken = 1'b1;
        forever begin
            @(posedge HCLK);
            #2;
            pclken = toggle ? ~pclken : 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s actual=%h required=%h", tname, nm, act, exp);
        end
    endtask

    task automatic tick_en();
        do @(posedge HCLK); while (!pclken);
        #1;
    endtask

    task automatic xfer(input bit wr, input logic [15:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr,
                        input logic [31:0] exp_rd, input bit exp_err, input int exp_w);
        int n;
        bit done;
        q.push_back('{exp_rd, exp_err, exp_w});
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a;
        pwdata = wd; pstrb = st; pprot = pr;
        tick_en();
        penable = 1'b1; xfer_active = 1'b1;
        n = 0; done = 1'b0;
        while (!done && n < 64) begin
            done = pready_m;
            tick_en();
            n++;
        end
        chk("completed", 32'(done), 32'd1);
        psel = 1'b0; penable = 1'b0; xfer_active = 1'b0;
    endtask

    // Monitor: looks at the bus just before each enabled edge in the access phase.
    initial begin
        mon_w = 0;
        forever begin
            @(negedge HCLK);
            if (!hresetn || !xfer_active) begin
                mon_w = 0;
            end else if (psel && penable && pclken) begin
                if (!pready_m) begin
                    mon_w++;
                end else if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL %s/unexpected_completion actual=1 required=0", tname);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("PRDATA",  prdata_m, e.rd);
                    chk("PSLVERR", 32'(pslverr_m), 32'(e.err));
                    chk("waits",   32'(mon_w), 32'(e.w));
                    mon_w = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        tname = "reset"; toggle = 1'b0; dsel = 1'b0; xfer_active = 1'b0;
        hresetn = 1'b0; psel = 0; penable = 0; pwrite = 0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("PREADY", 32'(pready_m), 32'd1);
        chk("PSLVERR", 32'(pslverr_m), 32'd0);
        chk("PRDATA", prdata_m, 32'd0);
        hresetn = 1'b1;

        tname = "basic";
        xfer(1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0, 0, 0);
        xfer(0, 16'h0010, 32'h0,        4'hF, 3'b000, 32'hDEADBEEF, 0, 0);

        tname = "strobe";
        xfer(1, 16'h0020, 32'h11223344, 4'hF, 3'b000, 32'h0, 0, 0);
        xfer(1, 16'h0020, 32'hAABBCCDD, 4'h5, 3'b000, 32'h0, 0, 0);
        xfer(0, 16'h0020, 32'h0,        4'h0, 3'b000, 32'h11BB33DD, 0, 0);
        xfer(1, 16'h0010, 32'hFFFFFFFF, 4'h0, 3'b000, 32'h0, 0, 0);
        xfer(0, 16'h0010, 32'h0,        4'h0, 3'b000, 32'hDEADBEEF, 0, 0);

        tname = "range";
        xfer(1, 16'h0000, 32'h55AA55AA, 4'hF, 3'b001, 32'h0, 0, 0);
        xfer(1, 16'h1000, 32'h12345678, 4'hF, 3'b001, 32'h0, 1, 0);
        xfer(0, 16'h1000, 32'h0,        4'h0, 3'b001, 32'h0, 1, 0);
        xfer(0, 16'h0000, 32'h0,        4'h0, 3'b001, 32'h55AA55AA, 0, 0);

        tname = "priv";
        xfer(1, 16'h0004, 32'h01020304, 4'hF, 3'b001, 32'h0, 0, 0);
        xfer(1, 16'h0004, 32'hCAFEF00D, 4'hF, 3'b000, 32'h0, 1, 0);
        xfer(0, 16'h0004, 32'h0,        4'h0, 3'b001, 32'h01020304, 0, 0);
        xfer(0, 16'h0004, 32'h0,        4'h0, 3'b000, 32'h0, 1, 0);
        xfer(1, 16'h0004, 32'hCAFEF00D, 4'hF, 3'b001, 32'h0, 0, 0);
        xfer(0, 16'h0004, 32'h0,        4'h0, 3'b001, 32'hCAFEF00D, 0, 0);

        tname = "no_setup";
        psel = 1; penable = 1; pwrite = 1; paddr = 16'h0010; pwdata = 32'h0; pstrb = 4'hF;
        tick_en(); tick_en();
        chk("PREADY_idle", 32'(pready_m), 32'd1);
        psel = 0; penable = 0;
        xfer(0, 16'h0010, 32'h0, 4'h0, 3'b000, 32'hDEADBEEF, 0, 0);

        tname = "waits";
        dsel = 1'b1; toggle = 1'b1;
        tick_en();
        xfer(1, 16'h0040, 32'h13579BDF, 4'hF, 3'b000, 32'h0, 0, 3);
        xfer(0, 16'h0040, 32'h0,        4'h0, 3'b000, 32'h13579BDF, 0, 3);

        tname = "mid_reset";
        psel = 1; penable = 0; pwrite = 1; paddr = 16'h0040; pwdata = 32'h0; pstrb = 4'hF;
        tick_en();
        penable = 1;
        tick_en();
        chk("PREADY_wait", 32'(pready_m), 32'd0);
        hresetn = 1'b0; psel = 0; penable = 0;
        #1;
        chk("PREADY", 32'(pready_m), 32'd1);
        chk("PSLVERR", 32'(pslverr_m), 32'd0);
        chk("PRDATA", prdata_m, 32'd0);
        repeat (2) @(posedge HCLK);
        #1 hresetn = 1'b1;
        xfer(0, 16'h0040, 32'h0, 4'h0, 3'b000, 32'h13579BDF, 0, 3);

        tname = "abort";
        psel = 1; penable = 0; pwrite = 1; paddr = 16'h0040; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        tick_en();
        penable = 1;
        tick_en();
        chk("PREADY_wait", 32'(pready_m), 32'd0);
        psel = 0; penable = 0;
        tick_en();
        chk("PREADY_idle", 32'(pready_m), 32'd1);
        xfer(0, 16'h0040, 32'h0, 4'h0, 3'b000, 32'h13579BDF, 0, 3);

        tname = "drain";
        repeat (4) @(posedge HCLK);
        chk("queue_left", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
